// File: rtl/mac_window_feeder.sv
// ---------------------------------------------------------------------------
// mac_window_feeder
//
// Purpose:
//    Loads one KxK filter (K = 2..5) and one binary IFMAP_DIM x IFMAP_DIM
//    ifmap, then walks a KxK window over the ifmap at stride 1 in row-major
//    order. For every output position it presents one packet to the PE MAC:
//    latched size, the five filter rows and the packed binary window.
//
// Ports:
//    clk, rst            clock (rising edge) and synchronous active-high reset
//    cfg_valid/ready     configuration handshake, cfg_size selects K-2
//    flt_valid/ready     filter row handshake, flt_data carries 5 weights
//    ifm_valid/ready     ifmap row handshake, ifm_row bit j = column j
//    pkt_valid/ready     packet handshake towards the MAC
//    pkt_size            latched cfg_size
//    pkt_filter_row1..5  filter rows, row1 is the top row
//    pkt_ifmap           window, element (i,j) at bit (K-1-i)*K + j
//    pkt_row, pkt_col    output position of the packet on offer
//    done                one-cycle pulse after the last packet transfers
// ---------------------------------------------------------------------------
module mac_window_feeder #(
   parameter int FILTER_WIDTH = 8,
   parameter int IFMAP_DIM    = 10,
   parameter int IFMAP_WIDTH  = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      cfg_valid,
   output logic                      cfg_ready,
   input  logic [1:0]                cfg_size,
   input  logic                      flt_valid,
   output logic                      flt_ready,
   input  logic [5*FILTER_WIDTH-1:0] flt_data,
   input  logic                      ifm_valid,
   output logic                      ifm_ready,
   input  logic [IFMAP_DIM-1:0]      ifm_row,
   output logic                      pkt_valid,
   input  logic                      pkt_ready,
   output logic [1:0]                pkt_size,
   output logic [5*FILTER_WIDTH-1:0] pkt_filter_row1,
   output logic [5*FILTER_WIDTH-1:0] pkt_filter_row2,
   output logic [5*FILTER_WIDTH-1:0] pkt_filter_row3,
   output logic [5*FILTER_WIDTH-1:0] pkt_filter_row4,
   output logic [5*FILTER_WIDTH-1:0] pkt_filter_row5,
   output logic [24:0]               pkt_ifmap,
   output logic [3:0]                pkt_row,
   output logic [3:0]                pkt_col,
   output logic                      done
);

   localparam int FW     = FILTER_WIDTH;
   localparam int DIM    = IFMAP_DIM;
   localparam int ROW_W  = IFMAP_DIM * IFMAP_WIDTH;
   localparam int IFM_W  = DIM * ROW_W;
   localparam int IFM_AW = $clog2(IFM_W);
   localparam logic [3:0] DIM_LAST = 4'(DIM - 1);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_LOAD_FLT = 3'd1,
      ST_LOAD_IFM = 3'd2,
      ST_SEND     = 3'd3,
      ST_DONE     = 3'd4
   } state_t;

   state_t              state_r;
   state_t              state_nxt_s;
   logic [1:0]          size_r;
   logic [3:0]          cnt_r;
   logic [3:0]          row_r;
   logic [3:0]          col_r;
   logic                cfg_ready_r;
   logic                flt_ready_r;
   logic                ifm_ready_r;
   logic                pkt_valid_r;
   logic [24:0]         pkt_ifmap_r;
   logic                done_r;
   logic [5*FW-1:0]     flt_r [5];
   logic [IFM_W-1:0]    ifm_r;

   logic                cfg_fire_s;
   logic                flt_fire_s;
   logic                ifm_fire_s;
   logic                xfer_s;
   logic                load_pos_s;
   logic [3:0]          nxt_row_s;
   logic [3:0]          nxt_col_s;
   logic [2:0]          k_s;
   logic [3:0]          k_last_s;
   logic [3:0]          pos_last_s;
   logic [IFM_W-1:0]    ifm_view_s;

   // Zero the weight slots that lie outside a KxK filter.
   function automatic logic [5*FW-1:0] mask_row_f(input logic [5*FW-1:0] row,
                                                  input logic [2:0]      k);
      logic [5*FW-1:0] m;
      m = row;
      for (int c = 0; c < 5; c++) begin
         if (c >= int'(k)) begin
            m[c*FW +: FW] = {FW{1'b0}};
         end else begin
            m[c*FW +: FW] = row[c*FW +: FW];
         end
      end
      return m;
   endfunction

   // Extract the KxK window at (r,c); the top window row lands in the
   // highest occupied group of K bits, unused bits stay 0.
   function automatic logic [24:0] window_f(input logic [IFM_W-1:0] img,
                                            input logic [3:0]       r,
                                            input logic [3:0]       c,
                                            input logic [2:0]       k);
      logic [24:0] w;
      int          ri;
      int          cj;
      int          bit_i;
      w = 25'd0;
      for (int i = 0; i < 5; i++) begin
         for (int j = 0; j < 5; j++) begin
            ri    = int'(r) + i;
            cj    = int'(c) + j;
            bit_i = (int'(k) - 1 - i) * int'(k) + j;
            if (i < int'(k) && j < int'(k) && ri < DIM && cj < DIM) begin
               w[5'(bit_i)] = img[IFM_AW'(ri * ROW_W + cj)];
            end else begin
               w = w;
            end
         end
      end
      return w;
   endfunction

   // Geometry derived from the latched size.
   always_comb begin
      k_s        = {1'b0, size_r} + 3'd2;
      k_last_s   = {2'b00, size_r} + 4'd1;
      // DIM - K, i.e. the last output index; modulo-16 keeps DIM = 16 right.
      pos_last_s = 4'(DIM) - {1'b0, k_s};
   end

   // Ifmap contents as they will be after this cycle, so the first window
   // can be formed in the same cycle as the last row is accepted.
   always_comb begin
      ifm_view_s = ifm_r;
      for (int i = 0; i < DIM; i++) begin
         if (ifm_fire_s && cnt_r == 4'(i)) begin
            ifm_view_s[i*ROW_W +: ROW_W] = ifm_row;
         end else begin
            ifm_view_s[i*ROW_W +: ROW_W] = ifm_r[i*ROW_W +: ROW_W];
         end
      end
   end

   // Next-state, handshake fires and next output position.
   always_comb begin
      state_nxt_s = state_r;
      cfg_fire_s  = cfg_valid && cfg_ready_r;
      flt_fire_s  = flt_valid && flt_ready_r;
      ifm_fire_s  = ifm_valid && ifm_ready_r;
      xfer_s      = pkt_valid_r && pkt_ready;
      load_pos_s  = 1'b0;
      nxt_row_s   = row_r;
      nxt_col_s   = col_r;
      case (state_r)
         ST_IDLE: begin
            if (cfg_fire_s) begin
               state_nxt_s = ST_LOAD_FLT;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_LOAD_FLT: begin
            if (flt_fire_s && cnt_r == k_last_s) begin
               state_nxt_s = ST_LOAD_IFM;
            end else begin
               state_nxt_s = ST_LOAD_FLT;
            end
         end
         ST_LOAD_IFM: begin
            if (ifm_fire_s && cnt_r == DIM_LAST) begin
               state_nxt_s = ST_SEND;
               load_pos_s  = 1'b1;
               nxt_row_s   = 4'd0;
               nxt_col_s   = 4'd0;
            end else begin
               state_nxt_s = ST_LOAD_IFM;
            end
         end
         ST_SEND: begin
            if (xfer_s) begin
               if (row_r == pos_last_s && col_r == pos_last_s) begin
                  state_nxt_s = ST_DONE;
               end else begin
                  load_pos_s = 1'b1;
                  if (col_r == pos_last_s) begin
                     nxt_col_s = 4'd0;
                     nxt_row_s = row_r + 4'd1;
                  end else begin
                     nxt_col_s = col_r + 4'd1;
                  end
               end
            end else begin
               state_nxt_s = ST_SEND;
            end
         end
         ST_DONE: begin
            state_nxt_s = ST_IDLE;
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // State register and registered readies/valid/done decoded from next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         cfg_ready_r <= 1'b1;
         flt_ready_r <= 1'b0;
         ifm_ready_r <= 1'b0;
         pkt_valid_r <= 1'b0;
         done_r      <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         cfg_ready_r <= (state_nxt_s == ST_IDLE);
         flt_ready_r <= (state_nxt_s == ST_LOAD_FLT);
         ifm_ready_r <= (state_nxt_s == ST_LOAD_IFM);
         pkt_valid_r <= (state_nxt_s == ST_SEND);
         done_r      <= (state_nxt_s == ST_DONE);
      end
   end

   // Size latch and shared row counter for the two load phases.
   always_ff @(posedge clk) begin
      if (rst) begin
         size_r <= 2'd0;
         cnt_r  <= 4'd0;
      end else begin
         if (cfg_fire_s) begin
            size_r <= cfg_size;
         end
         if (cfg_fire_s || (flt_fire_s && cnt_r == k_last_s)) begin
            cnt_r <= 4'd0;
         end else if (flt_fire_s || ifm_fire_s) begin
            cnt_r <= cnt_r + 4'd1;
         end
      end
   end

   // Filter storage: cleared on a new configuration so rows above K read 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < 5; r++) begin
            flt_r[r] <= {(5*FW){1'b0}};
         end
      end else begin
         for (int r = 0; r < 5; r++) begin
            if (cfg_fire_s) begin
               flt_r[r] <= {(5*FW){1'b0}};
            end else if (flt_fire_s && cnt_r == 4'(r)) begin
               flt_r[r] <= mask_row_f(flt_data, k_s);
            end
         end
      end
   end

   // Ifmap storage, one row per accepted transfer.
   always_ff @(posedge clk) begin
      if (rst) begin
         ifm_r <= {IFM_W{1'b0}};
      end else if (ifm_fire_s) begin
         ifm_r <= ifm_view_s;
      end
   end

   // Packet position and window, updated only when a new position is presented.
   always_ff @(posedge clk) begin
      if (rst) begin
         row_r       <= 4'd0;
         col_r       <= 4'd0;
         pkt_ifmap_r <= 25'd0;
      end else if (load_pos_s) begin
         row_r       <= nxt_row_s;
         col_r       <= nxt_col_s;
         pkt_ifmap_r <= window_f(ifm_view_s, nxt_row_s, nxt_col_s, k_s);
      end
   end

   assign cfg_ready       = cfg_ready_r;
   assign flt_ready       = flt_ready_r;
   assign ifm_ready       = ifm_ready_r;
   assign pkt_valid       = pkt_valid_r;
   assign pkt_size        = size_r;
   assign pkt_filter_row1 = flt_r[0];
   assign pkt_filter_row2 = flt_r[1];
   assign pkt_filter_row3 = flt_r[2];
   assign pkt_filter_row4 = flt_r[3];
   assign pkt_filter_row5 = flt_r[4];
   assign pkt_ifmap       = pkt_ifmap_r;
   assign pkt_row         = row_r;
   assign pkt_col         = col_r;
   assign done            = done_r;

endmodule

// File: doc/mac_window_feeder.md
Name: mac_window_feeder

Overview:
- Clocked producer that drives the PE MAC input bundle: size, filter rows 1-5 and the packed binary ifmap window.
- Loads one filter (2x2 to 5x5) and one binary IFMAP_DIM x IFMAP_DIM ifmap.
- Slides a KxK window at stride 1 in row-major order.
- Emits one packet per output position over a valid/ready handshake; the MAC consumes each packet and returns one sum.

Parameters:
FILTER_WIDTH, 8, bits per filter weight
IFMAP_DIM, 10, ifmap rows = columns (legal 5..16)
IFMAP_WIDTH, 1, bits per ifmap element (fixed at 1)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
cfg_valid  in  1  configuration offered
cfg_ready  out  1  feeder idle and accepting configuration
cfg_size  in  2  00=2x2, 01=3x3, 10=4x4, 11=5x5
flt_valid  in  1  filter row offered
flt_ready  out  1  filter row accepted when flt_valid&&flt_ready
flt_data  in  5*FILTER_WIDTH  weight c at bits [FW*(c+1)-1:FW*c]
ifm_valid  in  1  ifmap row offered
ifm_ready  out  1  ifmap row accepted when ifm_valid&&ifm_ready
ifm_row  in  IFMAP_DIM  bit j = column j
pkt_valid  out  1  packet valid
pkt_ready  in  1  MAC side accepts packet
pkt_size  out  2  latched cfg_size
pkt_filter_row1..5  out  5*FILTER_WIDTH each  filter rows, row1 = top
pkt_ifmap  out  25  packed window
pkt_row, pkt_col  out  4 each  output position of current packet
done  out  1  one-cycle pulse after last packet transfers

Behaviour:
- Decided interface rule: one clock (clk); reset (rst) is synchronous and active-high.
- While rst is high on a rising edge: state=IDLE and all outputs 0, except cfg_ready, which is 1 from the first cycle after reset. Any handshake in progress is abandoned (reset mid-operation included). Filter and ifmap storage are cleared to 0.
- K = cfg_size+2. OUT_DIM = IFMAP_DIM-K+1.
- FSM:
  - IDLE: cfg_ready=1. On cfg_valid, latch size and go to LOAD_FLT.
  - LOAD_FLT: flt_ready=1. Accept exactly K rows, in order row1..rowK.
    - Slots c>=K are zeroed on capture.
    - Rows K+1..5 stay 0.
    - After the K-th accept, go to LOAD_IFM.
  - LOAD_IFM: ifm_ready=1. Accept exactly IFMAP_DIM rows, top row first. After the last accept, go to SEND.
  - SEND: packets for positions (r,c), r and c each 0..OUT_DIM-1, col fastest.
  - DONE: done=1 for one cycle, then IDLE.
- Window packing: window element (i,j), i = row offset 0..K-1 (0 = top, pairs with filter_row1), j = column offset, maps to pkt_ifmap bit (K-1-i)*K + j. Bits >= K*K are 0.
- Timing in SEND:
  - pkt_valid rises in the first SEND cycle, i.e. the cycle after the last ifmap accept. Window fields are registered.
  - All pkt_* outputs are held stable while pkt_valid && !pkt_ready.
  - On a transfer (pkt_valid&&pkt_ready), the next position is presented the following cycle with pkt_valid still 1. Throughput is 1 packet per cycle. There are no bubbles, skips or repeats.
  - Position advance: col wraps at OUT_DIM-1 to 0 and row increments.
  - On transfer of (OUT_DIM-1, OUT_DIM-1): pkt_valid=0 next cycle and state=DONE.
- Handshake gating:
  - The ready of any channel not owned by the current state is 0.
  - Offers on those channels are ignored and not buffered.
- No valid may depend combinationally on a ready.
- cfg_size is not re-sampled until IDLE.

Test Plan:
1. Stimulus: size=01; flt rows 0x0000030201, 0x0000060504, 0x0000090807; all-ones ifmap, IFMAP_DIM=10. Response: 64 packets; each has pkt_ifmap=0x1FF, pkt_filter_row4/5=0, pkt_filter_row1=0x0000030201; done pulses once after the 64th.
2. Stimulus: size=11; ifmap with only (0,0)=1. Response: packet (0,0) has pkt_ifmap=0x0100000 (bit 20 only); packets (0,1) and (1,0) have pkt_ifmap=0; 36 packets total.
3. Stimulus: size=00 with flt_data=0xFFFFFFFFFF for both rows. Response: pkt_filter_row1=row2=0x000000FFFF, rows3-5=0; 81 packets; last packet pkt_row=pkt_col=8.
4. Stimulus: size=10; pkt_ready low 5 cycles at packet (2,3), plus a random 50% ready pattern. Response: fields stable during the stall; exactly 49 distinct positions in row-major order; done once.
5. Stimulus: rst high for 1 cycle mid-SEND at position (1,4). Response: next cycle pkt_valid=0, done=0, cfg_ready=1; a following full 3x3 run produces 64 correct packets.
6. Stimulus: flt_valid/ifm_valid asserted during IDLE, and extra rows offered after loading completes. Response: ready held 0, nothing captured, packet contents unaffected.
